// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and data memory) sharing a single
// fixed-latency memory port; one transaction is in flight at a time.
module mem_port_arbiter #(
  parameter int DBITS      = 32,
  parameter int ABITS      = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_valid,
  input  logic [ABITS-1:0] if_req_addr,
  output logic             if_req_ready,
  output logic             if_resp_valid,
  output logic [DBITS-1:0] if_resp_data,
  input  logic             dm_req_valid,
  input  logic             dm_req_we,
  input  logic [ABITS-1:0] dm_req_addr,
  input  logic [DBITS-1:0] dm_req_wdata,
  output logic             dm_req_ready,
  output logic             dm_resp_valid,
  output logic [DBITS-1:0] dm_resp_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             own_dm_q, own_dm_d;
  logic             we_q, we_d;
  logic [3:0]       starve_q, starve_d;
  logic [DBITS-1:0] if_data_q, if_data_d;
  logic [DBITS-1:0] dm_data_q, dm_data_d;

  logic arb_en;
  logic grant_if;
  logic grant_dm;
  logic xfer;

  // Handshake: a request transfers in the cycle where valid && ready. Ready is
  // combinational, given only to the arbitration winner, and only in IDLE or
  // RESP while reset is released; requesters hold valid/payload until accepted.
  assign arb_en   = reset && ((state_q == IDLE) || (state_q == RESP));
  assign grant_dm = arb_en && dm_req_valid && !(if_req_valid && (starve_q == STARVE_CAP));
  assign grant_if = arb_en && if_req_valid && !grant_dm;
  assign xfer     = grant_if || grant_dm;

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  assign mem_en    = xfer;
  assign mem_we    = grant_dm && dm_req_we;
  assign mem_addr  = grant_dm ? dm_req_addr : (grant_if ? if_req_addr : '0);
  assign mem_wdata = grant_dm ? dm_req_wdata : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_dm_d  = own_dm_q;
    we_d      = we_q;
    starve_d  = starve_q;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;

    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Read data is on mem_rdata exactly MEM_LAT cycles after the transfer.
          if (own_dm_q) begin
            dm_data_d = we_q ? '0 : mem_rdata;
          end else begin
            if_data_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      state_d  = WAIT;
      cnt_d    = LAT_M1;
      own_dm_d = grant_dm;
      we_d     = grant_dm && dm_req_we;
    end

    if (grant_dm) begin
      if (!if_req_valid) begin
        starve_d = 4'd0;
      end else if (starve_q < STARVE_CAP) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (grant_if) begin
      starve_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      own_dm_q  <= 1'b0;
      we_q      <= 1'b0;
      starve_q  <= 4'd0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_dm_q  <= own_dm_d;
      we_q      <= we_d;
      starve_q  <= starve_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  assign if_resp_valid = (state_q == RESP) && !own_dm_q;
  assign dm_resp_valid = (state_q == RESP) && own_dm_q;
  assign if_resp_data  = if_data_q;
  assign dm_resp_data  = dm_data_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and a memory model.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        dm_req_valid;
  logic        dm_req_we;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_data;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DBITS(32), .ABITS(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // requester intent
  logic        rst_val = 1'b0;
  logic        if_pend = 1'b0;
  logic [31:0] if_addr_r = '0;
  logic        dm_pend = 1'b0;
  logic        dm_we_r = 1'b0;
  logic [31:0] dm_addr_r = '0;
  logic [31:0] dm_wdata_r = '0;

  // memory attached to the DUT port
  logic [31:0] phys_mem [logic [31:0]];
  int          rd_cyc_q [$];
  logic [31:0] rd_dat_q [$];

  // reference model
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_q [$];
  int          exp_cyc_q [$];
  logic        exp_own_q [$];
  int          next_ok = 0;
  int          busy_until = -1;
  int          starve = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  logic        exp_if_ready, exp_dm_ready, exp_mem_en, exp_mem_we, exp_busy;
  logic        exp_if_rv, exp_dm_rv;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_if_data, exp_dm_data;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 15) << 2);
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, advance models.
  task automatic step();
    logic win_if, win_dm;
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    reset        = rst_val;
    if_req_valid = if_pend;
    if_req_addr  = if_addr_r;
    dm_req_valid = dm_pend;
    dm_req_we    = dm_we_r;
    dm_req_addr  = dm_addr_r;
    dm_req_wdata = dm_wdata_r;
    while (rd_cyc_q.size() > 0 && rd_cyc_q[0] < cyc) begin
      rd_cyc_q.delete(0);
      rd_dat_q.delete(0);
    end
    if (rd_cyc_q.size() > 0 && rd_cyc_q[0] == cyc) begin
      mem_rdata = rd_dat_q.pop_front();
      rd_cyc_q.delete(0);
    end else begin
      mem_rdata = $urandom();
    end
    #1;
    if (mem_en) begin
      if (mem_we) phys_mem[mem_addr] = mem_wdata;
      else begin
        rd_cyc_q.push_back(cyc + L);
        rd_dat_q.push_back(phys_rd(mem_addr));
      end
    end

    exp_if_ready = 0; exp_dm_ready = 0; exp_mem_en = 0; exp_mem_we = 0;
    exp_mem_addr = '0; exp_mem_wdata = '0; exp_if_rv = 0; exp_dm_rv = 0; exp_busy = 0;
    if (!rst_val) begin
      exp_q.delete(); exp_cyc_q.delete(); exp_own_q.delete();
      rd_cyc_q.delete(); rd_dat_q.delete();
      starve = 0; last_if = '0; last_dm = '0;
      next_ok = cyc + 1; busy_until = -1;
    end else begin
      exp_busy = (cyc <= busy_until);
      win_if = 0; win_dm = 0;
      if (cyc >= next_ok) begin
        if (dm_pend && !(if_pend && starve == SMAX)) win_dm = 1;
        else if (if_pend) win_if = 1;
      end
      exp_if_ready  = win_if;
      exp_dm_ready  = win_dm;
      exp_mem_en    = win_if | win_dm;
      exp_mem_we    = win_dm & dm_we_r;
      exp_mem_addr  = win_dm ? dm_addr_r : (win_if ? if_addr_r : 32'h0);
      exp_mem_wdata = win_dm ? dm_wdata_r : 32'h0;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        exp_cyc_q.delete(0);
        d = exp_q.pop_front();
        if (exp_own_q.pop_front()) begin exp_dm_rv = 1; last_dm = d; end
        else begin exp_if_rv = 1; last_if = d; end
      end
      if (win_dm || win_if) begin
        if (win_dm && dm_we_r) begin
          d = 32'h0;
          ref_mem[dm_addr_r] = dm_wdata_r;
        end else begin
          d = ref_rd(win_dm ? dm_addr_r : if_addr_r);
        end
        exp_q.push_back(d);
        exp_cyc_q.push_back(cyc + L + 1);
        exp_own_q.push_back(win_dm);
        next_ok    = cyc + L + 1;
        busy_until = cyc + L + 1;
      end
      if (win_dm) starve = if_pend ? ((starve < SMAX) ? starve + 1 : starve) : 0;
      if (win_if) starve = 0;
      if (win_dm) dm_pend = 0;
      if (win_if) if_pend = 0;
    end
    exp_if_data = last_if;
    exp_dm_data = last_dm;
  endtask

  task automatic idle(input int n);
    if_pend = 0; dm_pend = 0;
    repeat (n) step();
  endtask

  task automatic apply_reset();
    if_pend = 0; dm_pend = 0;
    rst_val = 0;
    step(); step();
    rst_val = 1;
  endtask

  task automatic test_reset();
    rst_val = 0; if_pend = 1; if_addr_r = 32'h104; dm_pend = 1; dm_we_r = 0; dm_addr_r = 32'h108;
    step();
    n_checks++; if ({if_req_ready, dm_req_ready, mem_en, busy} !== 4'b0) begin n_errs++;
      $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", if_req_ready, dm_req_ready, mem_en, busy); end
    n_checks++; if ({if_resp_valid, dm_resp_valid, dbg_state} !== 4'b0) begin n_errs++;
      $display("FAIL reset_resp got=%b%b%b exp=0000", if_resp_valid, dm_resp_valid, dbg_state); end
    n_checks++; if ({if_resp_data, dm_resp_data, mem_addr, mem_wdata, mem_we} !== '0) begin n_errs++;
      $display("FAIL reset_data if=%h dm=%h addr=%h wd=%h we=%b exp=0", if_resp_data, dm_resp_data, mem_addr, mem_wdata, mem_we); end
    dm_pend = 0; rst_val = 1;
    step();
    n_checks++; if (if_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h104) begin n_errs++;
      $display("FAIL first_arb rdy=%b en=%b addr=%h exp=1 1 00000104", if_req_ready, mem_en, mem_addr); end
    idle(L + 3);
  endtask

  task automatic test_if_read();
    phys_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100]  = 32'hDEADBEEF;
    if_pend = 1; if_addr_r = 32'h100;
    step();
    n_checks++; if (if_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin n_errs++;
      $display("FAIL ifrd_issue rdy=%b en=%b we=%b addr=%h exp=1 1 0 00000100", if_req_ready, mem_en, mem_we, mem_addr); end
    for (int k = 1; k <= L; k++) begin
      step();
      n_checks++; if (if_resp_valid !== 1'b0 || busy !== 1'b1) begin n_errs++;
        $display("FAIL ifrd_wait T+%0d rv=%b busy=%b exp=0 1", k, if_resp_valid, busy); end
    end
    step();
    n_checks++; if (if_resp_valid !== 1'b1 || if_resp_data !== 32'hDEADBEEF || dm_resp_valid !== 1'b0) begin n_errs++;
      $display("FAIL ifrd_resp rv=%b data=%h dmrv=%b exp=1 deadbeef 0", if_resp_valid, if_resp_data, dm_resp_valid); end
    step();
    n_checks++; if (if_resp_valid !== 1'b0 || if_resp_data !== 32'hDEADBEEF || busy !== 1'b0) begin n_errs++;
      $display("FAIL ifrd_hold rv=%b data=%h busy=%b exp=0 deadbeef 0", if_resp_valid, if_resp_data, busy); end
    idle(2);
  endtask

  task automatic test_reset_in_wait();
    if_pend = 1; if_addr_r = 32'h200;
    step();
    n_checks++; if (if_req_ready !== 1'b1) begin n_errs++;
      $display("FAIL rstw_accept got=%b exp=1", if_req_ready); end
    step();
    dm_pend = 1; dm_we_r = 0; dm_addr_r = 32'h100;
    rst_val = 0;
    step();
    n_checks++; if ({busy, if_resp_valid, dm_resp_valid, mem_en, if_req_ready, dm_req_ready} !== 6'b0) begin n_errs++;
      $display("FAIL rstw_ctrl busy=%b irv=%b drv=%b en=%b ir=%b dr=%b exp=0", busy, if_resp_valid, dm_resp_valid, mem_en, if_req_ready, dm_req_ready); end
    n_checks++; if (if_resp_data !== 32'h0 || mem_addr !== 32'h0) begin n_errs++;
      $display("FAIL rstw_data ifdata=%h addr=%h exp=0", if_resp_data, mem_addr); end
    step();
    rst_val = 1;
    step();
    n_checks++; if (dm_req_ready !== 1'b1 || mem_addr !== 32'h100) begin n_errs++;
      $display("FAIL rstw_new_accept rdy=%b addr=%h exp=1 00000100", dm_req_ready, mem_addr); end
    for (int k = 1; k <= L; k++) begin
      step();
      n_checks++; if (if_resp_valid !== 1'b0 || dm_resp_valid !== 1'b0) begin n_errs++;
        $display("FAIL rstw_no_stale T+%0d irv=%b drv=%b exp=0 0", k, if_resp_valid, dm_resp_valid); end
    end
    step();
    n_checks++; if (dm_resp_valid !== 1'b1 || dm_resp_data !== 32'hDEADBEEF || if_resp_valid !== 1'b0) begin n_errs++;
      $display("FAIL rstw_new_resp drv=%b data=%h irv=%b exp=1 deadbeef 0", dm_resp_valid, dm_resp_data, if_resp_valid); end
    idle(2);
  endtask

  task automatic test_dm_write();
    dm_pend = 1; dm_we_r = 1; dm_addr_r = 32'h40; dm_wdata_r = 32'h1234;
    step();
    n_checks++; if (dm_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin n_errs++;
      $display("FAIL dmwr_issue rdy=%b en=%b we=%b addr=%h wd=%h exp=1 1 1 00000040 00001234", dm_req_ready, mem_en, mem_we, mem_addr, mem_wdata); end
    repeat (L) step();
    step();
    n_checks++; if (dm_resp_valid !== 1'b1 || dm_resp_data !== 32'h0) begin n_errs++;
      $display("FAIL dmwr_ack rv=%b data=%h exp=1 00000000", dm_resp_valid, dm_resp_data); end
    dm_pend = 1; dm_we_r = 0; dm_addr_r = 32'h40;
    step();
    n_checks++; if (dm_req_ready !== 1'b1 || mem_we !== 1'b0) begin n_errs++;
      $display("FAIL dmwr_rd_issue rdy=%b we=%b exp=1 0", dm_req_ready, mem_we); end
    repeat (L + 1) step();
    n_checks++; if (dm_resp_valid !== 1'b1 || dm_resp_data !== 32'h1234) begin n_errs++;
      $display("FAIL dmwr_readback rv=%b data=%h exp=1 00001234", dm_resp_valid, dm_resp_data); end
    idle(2);
  endtask

  task automatic test_contention();
    apply_reset();
    if_pend = 1; if_addr_r = 32'h110; dm_pend = 1; dm_we_r = 0; dm_addr_r = 32'h114;
    step();
    n_checks++; if (dm_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin n_errs++;
      $display("FAIL cont_first ir=%b dr=%b exp=0 1", if_req_ready, dm_req_ready); end
    for (int k = 1; k <= L; k++) begin
      step();
      n_checks++; if (if_req_ready !== 1'b0 || dm_req_ready !== 1'b0) begin n_errs++;
        $display("FAIL cont_wait T+%0d ir=%b dr=%b exp=0 0", k, if_req_ready, dm_req_ready); end
    end
    step();
    n_checks++; if (if_req_ready !== 1'b1 || dm_resp_valid !== 1'b1 || dm_resp_data !== ref_rd(32'h114)) begin n_errs++;
      $display("FAIL cont_if_in_resp ir=%b drv=%b data=%h exp=1 1 %h", if_req_ready, dm_resp_valid, dm_resp_data, ref_rd(32'h114)); end
    repeat (L + 1) step();
    n_checks++; if (if_resp_valid !== 1'b1 || if_resp_data !== ref_rd(32'h110)) begin n_errs++;
      $display("FAIL cont_if_resp rv=%b data=%h exp=1 %h", if_resp_valid, if_resp_data, ref_rd(32'h110)); end
    idle(2);
  endtask

  task automatic test_starve();
    int exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic gq [$];
    apply_reset();
    if_pend = 1; dm_pend = 1; dm_we_r = 0;
    for (int c = 0; c < 10 * (L + 1) + 1; c++) begin
      if_addr_r = rand_addr(); dm_addr_r = rand_addr();
      if (!if_pend) if_pend = 1;
      if (!dm_pend) dm_pend = 1;
      step();
      if (if_req_ready && dm_req_ready) begin n_checks++; n_errs++;
        $display("FAIL starve_both_ready cyc=%0d", cyc); end
      if (dm_req_ready) gq.push_back(1'b1);
      else if (if_req_ready) gq.push_back(1'b0);
    end
    n_checks++; if (gq.size() < 10) begin n_errs++;
      $display("FAIL starve_grant_count got=%0d exp>=10", gq.size()); end
    for (int i = 0; i < 10 && i < gq.size(); i++) begin
      n_checks++; if (gq[i] !== exp_seq[i][0]) begin n_errs++;
        $display("FAIL starve_seq[%0d] got=%s exp=%s", i, gq[i] ? "DM" : "IF", exp_seq[i] ? "DM" : "IF"); end
    end
    idle(L + 3);
  endtask

  task automatic test_back_to_back();
    int acc [$];
    if_pend = 1;
    for (int c = 0; c < 5 * (L + 1); c++) begin
      if (!if_pend) begin if_pend = 1; if_addr_r = rand_addr(); end
      step();
      n_checks++; if (if_req_ready && dm_req_ready) begin n_errs++;
        $display("FAIL b2b_both_ready cyc=%0d", cyc); end
      if (acc.size() > 0 && cyc <= acc[$] + L) begin
        n_checks++; if (if_req_ready !== 1'b0) begin n_errs++;
          $display("FAIL b2b_ready_in_wait cyc=%0d got=%b exp=0", cyc, if_req_ready); end
      end
      if (if_req_ready) acc.push_back(cyc);
    end
    n_checks++; if (acc.size() < 4) begin n_errs++;
      $display("FAIL b2b_accept_count got=%0d exp>=4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++; if (acc[i] - acc[i-1] != L + 1) begin n_errs++;
        $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, acc[i] - acc[i-1], L + 1); end
    end
    idle(L + 3);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if (!if_pend && $urandom_range(0, 99) < 45) begin if_pend = 1; if_addr_r = rand_addr(); end
      if (!dm_pend && $urandom_range(0, 99) < 45) begin
        dm_pend = 1; dm_we_r = 1'($urandom_range(0, 1)); dm_addr_r = rand_addr(); dm_wdata_r = $urandom();
      end
      step();
      n_checks++; if (if_req_ready !== exp_if_ready || dm_req_ready !== exp_dm_ready) begin n_errs++;
        $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, if_req_ready, dm_req_ready, exp_if_ready, exp_dm_ready); end
      n_checks++; if (mem_en !== exp_mem_en || mem_we !== exp_mem_we || mem_addr !== exp_mem_addr) begin n_errs++;
        $display("FAIL rnd_mem cyc=%0d got=%b %b %h exp=%b %b %h", cyc, mem_en, mem_we, mem_addr, exp_mem_en, exp_mem_we, exp_mem_addr); end
      if (exp_mem_we || !exp_mem_en) begin
        n_checks++; if (mem_wdata !== exp_mem_wdata) begin n_errs++;
          $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, exp_mem_wdata); end
      end
      n_checks++; if (if_resp_valid !== exp_if_rv || if_resp_data !== exp_if_data) begin n_errs++;
        $display("FAIL rnd_if_resp cyc=%0d got=%b %h exp=%b %h", cyc, if_resp_valid, if_resp_data, exp_if_rv, exp_if_data); end
      n_checks++; if (dm_resp_valid !== exp_dm_rv || dm_resp_data !== exp_dm_data) begin n_errs++;
        $display("FAIL rnd_dm_resp cyc=%0d got=%b %h exp=%b %h", cyc, dm_resp_valid, dm_resp_data, exp_dm_rv, exp_dm_data); end
      n_checks++; if (busy !== exp_busy) begin n_errs++;
        $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
    end
    idle(L + 3);
  endtask

  initial begin
    reset = 1'b0; if_req_valid = 0; if_req_addr = '0; dm_req_valid = 0; dm_req_we = 0;
    dm_req_addr = '0; dm_req_wdata = '0; mem_rdata = '0;
    test_reset();
    test_if_read();
    test_reset_in_wait();
    test_dm_write();
    test_contention();
    test_starve();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
